// File: rtl/mos6502s_store_unit.sv
// Store-side sequencer: picks a source register, forms the effective address
// and performs one memory write with req/ack handshake and ack timeout.
module mos6502s_store_unit #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  src_sel,
  input  logic [1:0]  idx_sel,
  input  logic        zp_mode,
  input  logic [7:0]  a,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [7:0]  p,
  input  logic [15:0] base_addr,
  input  logic [7:0]  sp_in,
  input  logic        mem_ack,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        done,
  output logic        err,
  output logic        sp_dec,
  output logic        page_cross
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, WRITE} state_t;

  state_t        state;
  logic [7:0]    data_q;
  logic [15:0]   base_q;
  logic [1:0]    idx_q;
  logic          zp_q;
  logic [7:0]    idxv_q;
  logic [7:0]    sp_q;
  logic [CW-1:0] cnt;

  logic [7:0]    src_data;
  logic [15:0]   calc_addr;
  logic          calc_cross;
  logic [15:0]   sum;
  logic [7:0]    zp_lo;

  always_comb begin
    src_data = a;
    case (src_sel)
      2'd0: src_data = a;
      2'd1: src_data = x;
      2'd2: src_data = y;
      default: src_data = p;
    endcase
  end

  // Carry out of bit 15 is discarded, so 0xFFFF+2 wraps to 0x0001.
  assign sum   = base_q + {8'h00, idxv_q};
  assign zp_lo = base_q[7:0] + idxv_q;

  always_comb begin
    calc_addr  = base_q;
    calc_cross = 1'b0;
    case (idx_q)
      2'd0: calc_addr = base_q;
      2'd1, 2'd2: begin
        if (zp_q) begin
          calc_addr = {8'h00, zp_lo};
        end else begin
          calc_addr  = sum;
          calc_cross = (sum[15:8] != base_q[15:8]);
        end
      end
      default: calc_addr = {8'h01, sp_q};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      data_q     <= '0;
      base_q     <= '0;
      idx_q      <= '0;
      zp_q       <= 1'b0;
      idxv_q     <= '0;
      sp_q       <= '0;
      cnt        <= '0;
      busy       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      sp_dec     <= 1'b0;
      page_cross <= 1'b0;
    end else begin
      done   <= 1'b0;
      err    <= 1'b0;
      sp_dec <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            data_q     <= src_data;
            base_q     <= base_addr;
            idx_q      <= idx_sel;
            zp_q       <= zp_mode;
            idxv_q     <= (idx_sel == 2'd1) ? x : y;
            sp_q       <= sp_in;
            page_cross <= 1'b0;
            busy       <= 1'b1;
            state      <= CALC;
          end
        end
        CALC: begin
          mem_addr   <= calc_addr;
          mem_wdata  <= data_q;
          page_cross <= calc_cross;
          cnt        <= '0;
          if (calc_cross) begin
            state <= FIX;
          end else begin
            mem_we <= 1'b1;
            state  <= WRITE;
          end
        end
        FIX: begin
          mem_we <= 1'b1;
          state  <= WRITE;
        end
        WRITE: begin
          // Ack is checked first so it wins over a same-edge timeout.
          if (mem_ack) begin
            mem_we <= 1'b0;
            done   <= 1'b1;
            sp_dec <= (idx_q == 2'd3);
            busy   <= 1'b0;
            state  <= IDLE;
          end else if (cnt == CNT_LAST) begin
            mem_we <= 1'b0;
            err    <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mos6502s_store_unit.sv
// Directed bench for mos6502s_store_unit; outputs sampled on the falling edge.
module tb_mos6502s_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  src_sel;
  logic [1:0]  idx_sel;
  logic        zp_mode;
  logic [7:0]  a, x, y, p;
  logic [15:0] base_addr;
  logic [7:0]  sp_in;
  logic        mem_ack;
  logic        busy;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        done;
  logic        err;
  logic        sp_dec;
  logic        page_cross;

  int vectors = 0;
  int miscompares = 0;

  mos6502s_store_unit #(.ACK_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .start(start), .src_sel(src_sel), .idx_sel(idx_sel),
    .zp_mode(zp_mode), .a(a), .x(x), .y(y), .p(p), .base_addr(base_addr),
    .sp_in(sp_in), .mem_ack(mem_ack), .busy(busy), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .done(done), .err(err),
    .sp_dec(sp_dec), .page_cross(page_cross)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issues a start pulse from a falling edge; returns in cycle 1 after E0.
  task automatic start_op(input logic [1:0] s, input logic [1:0] i, input logic z,
                          input logic [15:0] b);
    src_sel = s; idx_sel = i; zp_mode = z; base_addr = b;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int n;
    logic seen;
    rst = 1'b1; start = 0; src_sel = 0; idx_sel = 0; zp_mode = 0;
    a = 0; x = 0; y = 0; p = 0; base_addr = 0; sp_in = 0; mem_ack = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_pc", page_cross, 0);
    rst = 1'b0;
    step();

    // 1: STA abs; A changes after start must not leak in
    a = 8'h5A;
    start_op(2'd0, 2'd0, 1'b0, 16'h1234);
    a = 8'hEE;
    check("t1_busy_c1", busy, 1);
    check("t1_we_c1", mem_we, 0);
    mem_ack = 1'b1;
    step();
    check("t1_we_c2", mem_we, 1);
    check("t1_addr", mem_addr, 16'h1234);
    check("t1_data", mem_wdata, 16'h005A);
    step();
    mem_ack = 1'b0;
    check("t1_done_c3", done, 1);
    check("t1_we_c3", mem_we, 0);
    check("t1_busy_c3", busy, 0);
    check("t1_spdec", sp_dec, 0);
    step();
    check("t1_done_pulse", done, 0);

    // 2: STX abs,Y with page cross
    x = 8'h77; y = 8'h20;
    start_op(2'd1, 2'd2, 1'b0, 16'h12F0);
    step();
    check("t2_fix_we", mem_we, 0);
    check("t2_fix_busy", busy, 1);
    check("t2_pc", page_cross, 1);
    mem_ack = 1'b1;
    step();
    check("t2_we_c3", mem_we, 1);
    check("t2_addr", mem_addr, 16'h1310);
    check("t2_data", mem_wdata, 16'h0077);
    step();
    mem_ack = 1'b0;
    check("t2_done_c4", done, 1);
    check("t2_pc_sticky", page_cross, 1);

    // 3: STY zp,X wraps inside page 0
    y = 8'h33; x = 8'h10;
    start_op(2'd2, 2'd1, 1'b1, 16'h00F8);
    mem_ack = 1'b1;
    step();
    check("t3_we_c2", mem_we, 1);
    check("t3_addr", mem_addr, 16'h0008);
    check("t3_data", mem_wdata, 16'h0033);
    check("t3_pc", page_cross, 0);
    step();
    mem_ack = 1'b0;
    check("t3_done", done, 1);

    // 4: PHP started in the done cycle of the previous op
    p = 8'hB4; sp_in = 8'hFD;
    start_op(2'd3, 2'd3, 1'b0, 16'h4444);
    check("t4_busy", busy, 1);
    mem_ack = 1'b1;
    step();
    check("t4_addr", mem_addr, 16'h01FD);
    check("t4_data", mem_wdata, 16'h00B4);
    step();
    mem_ack = 1'b0;
    check("t4_done", done, 1);
    check("t4_spdec", sp_dec, 1);
    step();
    check("t4_spdec_pulse", sp_dec, 0);

    // Address wrap 0xFFFF + X=2 and stack at sp=0
    a = 8'hC3; x = 8'h02;
    start_op(2'd0, 2'd1, 1'b0, 16'hFFFF);
    step();
    check("wrap_fix_we", mem_we, 0);
    mem_ack = 1'b1;
    step();
    check("wrap_addr", mem_addr, 16'h0001);
    check("wrap_pc", page_cross, 1);
    step();
    mem_ack = 1'b0;
    check("wrap_done", done, 1);
    sp_in = 8'h00;
    start_op(2'd0, 2'd3, 1'b0, 16'h0000);
    mem_ack = 1'b1;
    step();
    check("sp0_addr", mem_addr, 16'h0100);
    step();
    mem_ack = 1'b0;
    check("sp0_spdec", sp_dec, 1);

    // 5: ack withheld -> timeout after 15 cycles of mem_we
    a = 8'h21;
    start_op(2'd0, 2'd0, 1'b0, 16'h0300);
    step();
    n = 0; seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (mem_we) n++;
      check("t5_no_done", done, 0);
      if (err) begin
        seen = 1;
        break;
      end
      step();
    end
    check("t5_err_seen", seen, 1);
    check("t5_we_cycles", n[15:0], 16'd15);
    check("t5_we_low", mem_we, 0);
    check("t5_busy_low", busy, 0);
    check("t5_spdec", sp_dec, 0);
    start_op(2'd0, 2'd0, 1'b0, 16'h0400);
    check("t5_restart_busy", busy, 1);
    mem_ack = 1'b1;
    step();
    step();
    mem_ack = 1'b0;
    check("t5_restart_done", done, 1);

    // 6: start during WRITE is ignored
    a = 8'h11;
    start_op(2'd0, 2'd0, 1'b0, 16'h2000);
    step();
    a = 8'h99; base_addr = 16'h3000; start = 1'b1;
    step();
    start = 1'b0;
    check("t6_addr_hold", mem_addr, 16'h2000);
    check("t6_data_hold", mem_wdata, 16'h0011);
    check("t6_we_hold", mem_we, 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("t6_done", done, 1);
    step();
    check("t6_no_queue", busy, 0);

    // Reset mid-WRITE drops everything at once
    a = 8'h42;
    start_op(2'd0, 2'd3, 1'b0, 16'h0000);
    step();
    check("rst_mid_we_before", mem_we, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_we", mem_we, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_addr", mem_addr, 16'h0000);
    #2 rst = 1'b0;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("rst_mid_no_done", done, 0);
    check("rst_mid_no_spdec", sp_dec, 0);
    check("rst_mid_no_err", err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
